// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan stage: hex glyph table, idle codes, index sizing.
// Pure declarations; no logic, no latency, no flow control.
// Imported by seg_hex_decode and seg_scan.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Active-low glyphs {dp,g,f,e,d,c,b,a} with the decimal point off
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic int idx_width(input int digits);
        return (digits <= 1) ? 1 : $clog2(digits);
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Display-side bundle: value/dp/freeze toward the scanner, SEG/AN/frame_done back out.
// Wires only; no latency; no backpressure (the display always accepts).
// master = value source, slave = scanner.
interface seg_scan_if;
    logic [31:0] data;
    logic [7:0]  dp;
    logic        freeze;
    logic [7:0]  SEG;
    logic [7:0]  AN;
    logic        frame_done;

    modport master (output data, output dp, output freeze,
                    input  SEG,  input  AN, input  frame_done);
    modport slave  (input  data, input  dp, input  freeze,
                    output SEG,  output AN, output frame_done);
endinterface

// File: rtl/seg_hex_decode.sv
// Hex nibble plus decimal-point request to active-low cathode pattern.
// Purely combinational, zero latency.
// No flow control.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp_on,
    output logic [7:0] seg
);
    logic [7:0] glyph;

    always_comb begin
        glyph = HEX_SEG[nib];
        seg   = {~dp_on, glyph[6:0]};
    end
endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit hex display driver with per-frame shadow capture.
// Outputs registered, one cycle behind the digit index; frame is SCAN_DIV*DIGITS cycles.
// No backpressure; SEG_SCAN_LZ_BLANK_EN enables leading-zero blanking.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DIGITS   = 8
)(
    input  logic        clk,
    input  logic        clr,
    seg_scan_if.slave   bus
);
    localparam int IW = idx_width(DIGITS);
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [31:0]   shadow;
    logic          tick;
    logic          wrap;
    logic          blank;
    logic [3:0]    nib;
    logic [7:0]    seg_dec;
    logic [7:0]    an_dec;

    always_comb begin
        tick   = (cnt == CW'(SCAN_DIV - 1));
        wrap   = tick && (idx == IW'(DIGITS - 1));
        nib    = shadow[{idx, 2'b00} +: 4];
        an_dec = ~(8'b1 << idx);
    end

    seg_hex_decode u_dec (
        .nib   (nib),
        .dp_on (bus.dp[idx]),
        .seg   (seg_dec)
    );

`ifdef SEG_SCAN_LZ_BLANK_EN
    logic [7:0] lz;
    logic       run_zero;

    // A digit is leading-zero when it and every higher shown digit are zero
    always_comb begin
        lz       = '0;
        run_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run_zero = run_zero & (shadow[4*k +: 4] == 4'h0);
            lz[k]    = run_zero;
        end
    end

    assign blank = lz[idx];
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt            <= '0;
            idx            <= '0;
            shadow         <= '0;
            bus.SEG        <= SEG_BLANK;
            bus.AN         <= AN_OFF;
            bus.frame_done <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick)
                idx <= wrap ? '0 : idx + IW'(1);
            // Capture only at the wrap so a frame never mixes two values
            if (wrap && !bus.freeze)
                shadow <= bus.data;
            bus.frame_done <= wrap;
            bus.AN         <= blank ? AN_OFF    : an_dec;
            bus.SEG        <= blank ? SEG_BLANK : seg_dec;
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: directed scan/dp/freeze/reset steps then random traffic,
// checked against a cycle-count model for DIGITS=8 and DIGITS=4 instances.
module tb_seg_scan;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] data_v = '0;
    logic [7:0]  dp_v = '0;
    logic        freeze_v = 1'b0;

    int vectors = 0;
    int errs = 0;
    int n = 0;
    logic [31:0] sh8 = '0;
    logic [31:0] sh4 = '0;

    logic [7:0] glyph [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    always #5 clk = ~clk;

    seg_scan_if bus8 ();
    seg_scan_if bus4 ();

    assign bus8.data = data_v;
    assign bus8.dp = dp_v;
    assign bus8.freeze = freeze_v;
    assign bus4.data = data_v;
    assign bus4.dp = dp_v;
    assign bus4.freeze = freeze_v;

    seg_scan #(.SCAN_DIV(4), .DIGITS(8)) dut8 (.clk(clk), .clr(clr), .bus(bus8.slave));
    seg_scan #(.SCAN_DIV(4), .DIGITS(4)) dut4 (.clk(clk), .clr(clr), .bus(bus4.slave));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s at n=%0d: observed %h expected %h", tag, n, obs, exp);
        end
    endtask

    // {AN, SEG} expected while digit d of a display of `digits` shows value sh
    function automatic logic [15:0] expect_out(input logic [31:0] sh, input int d,
                                               input int digits, input logic [7:0] dpv);
        logic [7:0]  an;
        logic [7:0]  g;
        logic [3:0]  nib;
        logic [31:0] live;
        logic        blank;
        nib   = sh[4*d +: 4];
        g     = glyph[nib];
        an    = 8'hFF;
        an[d] = 1'b0;
        g[7]  = ~dpv[d];
        live  = (digits == 8) ? sh : (sh & ((32'h1 << (4*digits)) - 32'h1));
        blank = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (d > 0)
            blank = ((live >> (4*d)) == 32'h0);
`endif
        if (live === 32'hx) blank = 1'b0;
        return blank ? 16'hFFFF : {an, g};
    endfunction

    task automatic step();
        logic [15:0] e;
        @(posedge clk); #1;
        n++;
        e = expect_out(sh8, ((n-1)/4) % 8, 8, dp_v);
        chk("an8", bus8.AN, e[15:8]);
        chk("seg8", bus8.SEG, e[7:0]);
        chk("fd8", {7'b0, bus8.frame_done}, {7'b0, n % 32 == 0});
        e = expect_out(sh4, ((n-1)/4) % 4, 4, dp_v);
        chk("an4", bus4.AN, e[15:8]);
        chk("seg4", bus4.SEG, e[7:0]);
        chk("fd4", {7'b0, bus4.frame_done}, {7'b0, n % 16 == 0});
        if (n % 32 == 0 && !freeze_v) sh8 = data_v;
        if (n % 16 == 0 && !freeze_v) sh4 = data_v;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_an8"}, bus8.AN, 8'hFF);
        chk({tag, "_seg8"}, bus8.SEG, 8'hFF);
        chk({tag, "_fd8"}, {7'b0, bus8.frame_done}, 8'h00);
        chk({tag, "_an4"}, bus4.AN, 8'hFF);
        chk({tag, "_seg4"}, bus4.SEG, 8'hFF);
    endtask

    initial begin
        // Reset held across edges
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_reset("rst");
        end
        clr = 1'b1; n = 0; sh8 = '0; sh4 = '0;

        // Two frames of 12345678: first shows zeros, second the captured value
        data_v = 32'h12345678;
        for (int i = 0; i < 64; i++) step();

        // Decimal point on digit 0 only
        dp_v = 8'h01;
        for (int i = 0; i < 32; i++) step();
        dp_v = 8'h00;

        // Freeze across a wrap, then release
        freeze_v = 1'b1;
        data_v = 32'hFFFFFFFF;
        for (int i = 0; i < 36; i++) step();
        freeze_v = 1'b0;
        for (int i = 0; i < 40; i++) step();

`ifdef SEG_SCAN_LZ_BLANK_EN
        data_v = 32'h000000A5;
        for (int i = 0; i < 64; i++) step();
        data_v = 32'h0;
        for (int i = 0; i < 64; i++) step();
`endif

        // Asynchronous reset in the middle of digit 3
        for (int i = 0; i < 32 && ((n / 4) % 8) != 3; i++) step();
        step();
        clr = 1'b0;
        #1;
        chk_reset("async");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk_reset("hold");
        end
        clr = 1'b1; n = 0; sh8 = '0; sh4 = '0;
        step();

        // Random traffic
        for (int i = 0; i < 640; i++) begin
            if ($urandom_range(0, 7) == 0) data_v = $urandom;
            if ($urandom_range(0, 15) == 0) dp_v = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) data_v[31:16] = 16'h0;
            freeze_v = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Display stage downstream of the CPU core inside the board top.
- Takes the 32-bit value chosen for display (PC, instruction count, branch/jump counters, LED data) and time-multiplexes it as 8 hex digits.
- Drives the board's active-low 7-segment cathodes (SEG) and digit anodes (AN).
- Captures the value once per scan frame so digits never tear mid-frame.

Parameters:
- SCAN_DIV, 100000, clock cycles each digit stays lit; legal range ≥2. Bench uses 4.
- DIGITS, 8, number of scanned digits; legal range 1..8. AN bits at index ≥DIGITS are held at 1.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset; asynchronous, active-low.
- data  in  32  value to display; nibble k is shown on digit k (digit 0 = bits 3:0).
- dp  in  8  decimal-point request per digit; 1 = lit.
- freeze  in  1  1 = do not capture new data at the frame boundary.
- SEG  out  8  active-low cathodes. Bits 6:0 = g,f,e,d,c,b,a; bit 7 = dp.
- AN  out  8  active-low one-hot digit enable.
- frame_done  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (clr=0) is asynchronous and takes effect immediately, including mid-frame:
  - SEG=8'hFF, AN=8'hFF, frame_done=0.
  - Prescaler cnt=0, digit index idx=0, shadow register=0.
- Prescaler: cnt counts 0..SCAN_DIV-1.
  - tick = (cnt==SCAN_DIV-1).
  - On tick: cnt←0 and idx←(idx==DIGITS-1)?0:idx+1.
  - Each idx value is held for exactly SCAN_DIV cycles; a frame is SCAN_DIV*DIGITS cycles.
- Frame wrap is tick with idx==DIGITS-1. On that edge:
  - shadow←data if freeze=0; shadow unchanged if freeze=1.
  - frame_done←1 for exactly one cycle; otherwise frame_done←0.
- Outputs are registered from the current idx and shadow, so they lag idx by one cycle:
  - AN←~(8'b1<<idx).
  - SEG[6:0]←decode(shadow[4*idx+:4]).
  - SEG[7]←~dp[idx]. dp is sampled live, not shadowed.
  - First edge after reset release gives AN=8'hFE, SEG=8'hC0.
  - New shadow data appears on digit 0 one cycle after the wrap edge.
- Decode table (SEG, dp off), nibbles 0..F:
  - C0 F9 A4 B0 99 92 82 F8
  - 80 90 88 83 C6 A1 86 8E
- Simultaneous data change and wrap: the value present on the wrap edge is captured.
- freeze asserted only between wraps has no effect.
- Only one AN bit may be 0 at any time; no overlap, no cycle with two digits lit.

Optional Feature:
- Macro SEG_SCAN_LZ_BLANK_EN.
- Defined:
  - Leading-zero digits are blanked: AN stays 8'hFF and SEG=8'hFF during their slots.
  - A leading-zero digit is any digit k>0 where shadow nibbles k..DIGITS-1 are all zero.
  - Digit 0 is never blanked; scan timing is unchanged.
- Undefined: every digit is always shown.

Decomposition:
- Package seg_pkg:
  - 16-entry hex→segment constant table.
  - SEG_BLANK=8'hFF, AN_OFF=8'hFF.
  - Index width derived from DIGITS.
- One combinational sub-module seg_hex_decode: 4-bit nibble + dp → 8-bit SEG.
- Prescaler, index, shadow, blanking and output registers live in seg_scan.

Test Plan:
- Reset: hold clr=0, toggle clk → SEG=8'hFF, AN=8'hFF, frame_done=0. Assert clr=0 mid-digit-3 → outputs go FF/FF without waiting for a clock edge; after release, the first edge gives AN=8'hFE.
- Scan (SCAN_DIV=4, data=32'h12345678, dp=0):
  - Frame 1: AN steps FE,FD,…,7F every 4 cycles with SEG=C0 throughout.
  - frame_done pulses once at cycle 32.
  - Frame 2: digit0 SEG=80, digit1 F8, digit2 82, …, digit7 F9.
- DP: dp=8'h01, data nibble0=8 → digit-0 slot SEG=8'h00; other digits keep bit7=1.
- Freeze: freeze=1 across a wrap, data changed to 32'hFFFFFFFF → displayed digits unchanged. freeze=0 → all digits show 8E starting one cycle after the next wrap.
- Period: frame_done spacing = exactly 32 cycles (SCAN_DIV=4, DIGITS=8). DIGITS=4 → spacing 16, AN[7:4] always 1.
- With SEG_SCAN_LZ_BLANK_EN, data=32'h000000A5:
  - Digit0 SEG=92, digit1 SEG=88; AN bits 2..7 never 0.
  - data=0 → only digit0 lit with C0.
